// File: rtl/dc_bsp_pkg.sv
// -----------------------------------------------------------------------------
// dc_bsp_pkg
//   Shared BSP constants: interrupt bit assignments of the ASP sources, the
//   number of AVMM-visible interrupt sources and the word-address map and
//   control-bit positions of the ASP interrupt controller CSR block.
//   No ports (package).
// -----------------------------------------------------------------------------
package dc_bsp_pkg;

  // Bit position of each ASP interrupt source inside the irq_src vector.
  localparam int BSP_DMA_0_IRQ_BIT       = 0;
  localparam int BSP_KERNEL_IRQ_BIT      = 1;
  localparam int BSP_DMA_1_IRQ_BIT       = 2;
  localparam int BSP_AVMM_NUM_IRQ_USED   = 3;
  localparam int BSP_NUM_INTERRUPT_LINES = 4;

  // Bit positions inside the interrupt controller CTRL register.
  localparam int IRQ_CTRL_GEN_EN_BIT  = 0;
  localparam int IRQ_CTRL_CNT_CLR_BIT = 1;

  // CSR word addresses (64-bit words). COUNT[i] lives at IRQ_CSR_COUNT0 + i.
  typedef enum logic [3:0] {
    IRQ_CSR_STATUS  = 4'd0,
    IRQ_CSR_PENDING = 4'd1,
    IRQ_CSR_ENABLE  = 4'd2,
    IRQ_CSR_MODE    = 4'd3,
    IRQ_CSR_CTRL    = 4'd4,
    IRQ_CSR_COUNT0  = 4'd8
  } irq_csr_addr_e;

endpackage : dc_bsp_pkg

// File: rtl/asp_irq_src_slice.sv
// -----------------------------------------------------------------------------
// asp_irq_src_slice
//   Per-source state of the ASP interrupt controller: previous source sample,
//   pending flag, edge/level mode bit, enable mask bit and a saturating count
//   of pending-set events.
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   src_i          level-high interrupt source
//   mode_we_i/_wd_i   MODE bit write strobe / data (1 = edge, 0 = level)
//   en_we_i/en_wd_i   ENABLE bit write strobe / data
//   w1c_i          write-1-to-clear strobe for the pending flag
//   cnt_clr_i      zero the event counter (wins over an increment)
//   pend_o, mode_o, en_o, cnt_o   register contents
// -----------------------------------------------------------------------------
module asp_irq_src_slice
  import dc_bsp_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             src_i,
  input  logic             mode_we_i,
  input  logic             mode_wd_i,
  input  logic             en_we_i,
  input  logic             en_wd_i,
  input  logic             w1c_i,
  input  logic             cnt_clr_i,
  output logic             pend_o,
  output logic             mode_o,
  output logic             en_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic             src_q,  src_d;
  logic             pend_q, pend_d;
  logic             mode_q, mode_d;
  logic             en_q,   en_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             set_evt;
  logic             pend_rise;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    set_evt   = mode_q ? (src_i & ~src_q) : src_i;
    // Set is OR-ed in after the clear so a coincident set always wins.
    pend_d    = set_evt | (pend_q & ~w1c_i);
    pend_rise = pend_d & ~pend_q;
    src_d     = src_i;
    mode_d    = mode_we_i ? mode_wd_i : mode_q;
    en_d      = en_we_i ? en_wd_i : en_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (pend_rise) begin
      cnt_d = sat_inc(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q  <= 1'b0;
      pend_q <= 1'b0;
      mode_q <= 1'b1;
      en_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      src_q  <= src_d;
      pend_q <= pend_d;
      mode_q <= mode_d;
      en_q   <= en_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o = pend_q;
  assign mode_o = mode_q;
  assign en_o   = en_q;
  assign cnt_o  = cnt_q;

endmodule : asp_irq_src_slice

// File: rtl/asp_irq_ctrl.sv
// -----------------------------------------------------------------------------
// asp_irq_ctrl
//   Aggregates the ASP interrupt sources (DMA_0, kernel, DMA_1) into the single
//   level-high IRQ line sent to the host, with a 64-bit AVMM CSR slave exposing
//   status, pending (W1C), enable, mode, control and per-source event counts.
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   irq_src             level-high interrupt sources
//   csr_address         CSR word address
//   csr_read/csr_write  read / write request (never stalled)
//   csr_writedata       write data
//   csr_byteenable      write byte enables
//   csr_waitrequest     always 0
//   csr_readdata        read data, held between responses
//   csr_readdatavalid   one-cycle read response strobe
//   irq_out             aggregated interrupt to host
// -----------------------------------------------------------------------------
module asp_irq_ctrl
  import dc_bsp_pkg::*;
#(
  parameter int NUM_IRQ    = BSP_AVMM_NUM_IRQ_USED,
  parameter int CSR_ADDR_W = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_IRQ-1:0]    irq_src,
  input  logic [CSR_ADDR_W-1:0] csr_address,
  input  logic                  csr_read,
  input  logic                  csr_write,
  input  logic [63:0]           csr_writedata,
  input  logic [7:0]            csr_byteenable,
  output logic                  csr_waitrequest,
  output logic [63:0]           csr_readdata,
  output logic                  csr_readdatavalid,
  output logic                  irq_out
);

  localparam logic [CSR_ADDR_W-1:0] ADDR_STATUS  = CSR_ADDR_W'(IRQ_CSR_STATUS);
  localparam logic [CSR_ADDR_W-1:0] ADDR_PENDING = CSR_ADDR_W'(IRQ_CSR_PENDING);
  localparam logic [CSR_ADDR_W-1:0] ADDR_ENABLE  = CSR_ADDR_W'(IRQ_CSR_ENABLE);
  localparam logic [CSR_ADDR_W-1:0] ADDR_MODE    = CSR_ADDR_W'(IRQ_CSR_MODE);
  localparam logic [CSR_ADDR_W-1:0] ADDR_CTRL    = CSR_ADDR_W'(IRQ_CSR_CTRL);

  logic [NUM_IRQ-1:0] pend_vec;
  logic [NUM_IRQ-1:0] mode_vec;
  logic [NUM_IRQ-1:0] en_vec;
  logic [CNT_W-1:0]   cnt_arr [NUM_IRQ];

  logic               gen_en_q,  gen_en_d;
  logic               irq_out_q, irq_out_d;
  logic               rvalid_q,  rvalid_d;
  logic [63:0]        rdata_q,   rdata_d;
  logic [63:0]        rd_mux;

  logic               wr_b0;
  logic               we_pend;
  logic               we_en;
  logic               we_mode;
  logic               we_ctrl;
  logic               cnt_clr;
  logic               unused_ok;

  // Every stored bit (at most 8 sources, CTRL bits 0..1) lives in byte 0,
  // so byte 0's enable gates all writes; higher bytes carry nothing.
  assign wr_b0   = csr_write & csr_byteenable[0];
  assign we_pend = wr_b0 && (csr_address == ADDR_PENDING);
  assign we_en   = wr_b0 && (csr_address == ADDR_ENABLE);
  assign we_mode = wr_b0 && (csr_address == ADDR_MODE);
  assign we_ctrl = wr_b0 && (csr_address == ADDR_CTRL);
  // Counter clear is a write strobe only; nothing is stored, so it reads 0.
  assign cnt_clr = we_ctrl & csr_writedata[IRQ_CTRL_CNT_CLR_BIT];

  assign unused_ok = ^{csr_writedata, csr_byteenable};

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
    asp_irq_src_slice #(
      .CNT_W (CNT_W)
    ) u_slice (
      .clk       (clk),
      .reset_n   (reset_n),
      .src_i     (irq_src[i]),
      .mode_we_i (we_mode),
      .mode_wd_i (csr_writedata[i]),
      .en_we_i   (we_en),
      .en_wd_i   (csr_writedata[i]),
      .w1c_i     (we_pend & csr_writedata[i]),
      .cnt_clr_i (cnt_clr),
      .pend_o    (pend_vec[i]),
      .mode_o    (mode_vec[i]),
      .en_o      (en_vec[i]),
      .cnt_o     (cnt_arr[i])
    );
  end

  // Read mux samples register state before this edge's writes take effect.
  always_comb begin
    rd_mux = '0;
    if (csr_address == ADDR_STATUS) begin
      rd_mux[NUM_IRQ-1:0] = irq_src;
    end else if (csr_address == ADDR_PENDING) begin
      rd_mux[NUM_IRQ-1:0] = pend_vec;
    end else if (csr_address == ADDR_ENABLE) begin
      rd_mux[NUM_IRQ-1:0] = en_vec;
    end else if (csr_address == ADDR_MODE) begin
      rd_mux[NUM_IRQ-1:0] = mode_vec;
    end else if (csr_address == ADDR_CTRL) begin
      rd_mux[IRQ_CTRL_GEN_EN_BIT] = gen_en_q;
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (csr_address == CSR_ADDR_W'(int'(IRQ_CSR_COUNT0) + i)) begin
          rd_mux[CNT_W-1:0] = cnt_arr[i];
        end
      end
    end
  end

  always_comb begin
    gen_en_d  = we_ctrl ? csr_writedata[IRQ_CTRL_GEN_EN_BIT] : gen_en_q;
    // Built from the registered pending flags: one edge to latch pending,
    // a second edge to drive irq_out.
    irq_out_d = gen_en_q & (|(pend_vec & en_vec));
    rvalid_d  = csr_read;
    rdata_d   = csr_read ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gen_en_q  <= 1'b0;
      irq_out_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      gen_en_q  <= gen_en_d;
      irq_out_q <= irq_out_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign csr_waitrequest   = 1'b0;
  assign csr_readdata      = rdata_q;
  assign csr_readdatavalid = rvalid_q;
  assign irq_out           = irq_out_q;

endmodule : asp_irq_ctrl

// File: tb/tb_asp_irq_ctrl.sv
module tb_asp_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  irq_src;
  logic [3:0]  csr_address;
  logic        csr_read;
  logic        csr_write;
  logic [63:0] csr_writedata;
  logic [7:0]  csr_byteenable;
  logic        csr_waitrequest;
  logic [63:0] csr_readdata;
  logic        csr_readdatavalid;
  logic        irq_out;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  asp_irq_ctrl #(
    .NUM_IRQ    (3),
    .CSR_ADDR_W (4),
    .CNT_W      (8)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .irq_src           (irq_src),
    .csr_address       (csr_address),
    .csr_read          (csr_read),
    .csr_write         (csr_write),
    .csr_writedata     (csr_writedata),
    .csr_byteenable    (csr_byteenable),
    .csr_waitrequest   (csr_waitrequest),
    .csr_readdata      (csr_readdata),
    .csr_readdatavalid (csr_readdatavalid),
    .irq_out           (irq_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [3:0] a, input logic [63:0] d, input logic [7:0] be);
    csr_address    = a;
    csr_writedata  = d;
    csr_byteenable = be;
    csr_write      = 1'b1;
    tick();
    csr_write      = 1'b0;
    csr_byteenable = 8'h00;
  endtask

  task automatic csr_rd(input logic [3:0] a, output logic [63:0] d, output logic v);
    csr_address = a;
    csr_read    = 1'b1;
    tick();
    csr_read    = 1'b0;
    d = csr_readdata;
    v = csr_readdatavalid;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    logic v;
    reset_n = 1'b0;
    irq_src = 3'b111;
    repeat (5) tick();
    n_cmp++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL rst_irq_out: got %b want 0", irq_out); end
    n_cmp++; if (csr_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", csr_readdatavalid); end
    n_cmp++; if (csr_readdata !== 64'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", csr_readdata); end
    n_cmp++; if (csr_waitrequest !== 1'b0) begin n_fail++; $display("FAIL waitrequest: got %b want 0", csr_waitrequest); end
    reset_n = 1'b1;
    tick();
    csr_rd(4'd1, d, v);
    n_cmp++; if (v !== 1'b1) begin n_fail++; $display("FAIL rst_pend_valid: got %b want 1", v); end
    n_cmp++; if (d !== 64'd7) begin n_fail++; $display("FAIL rst_pending: got %h want %h", d, 64'd7); end
    for (int i = 0; i < 3; i++) begin
      csr_rd(4'(8 + i), d, v);
      n_cmp++; if (d !== 64'd1) begin n_fail++; $display("FAIL rst_count%0d: got %h want %h", i, d, 64'd1); end
    end
    irq_src = 3'b000;
    tick();
    n_cmp++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL rst_irq_masked: got %b want 0", irq_out); end
  endtask

  task automatic test_edge();
    csr_wr(4'd1, 64'd7, 8'h01);
    csr_wr(4'd2, 64'd2, 8'h01);
    csr_wr(4'd4, 64'd1, 8'h01);
    n_cmp++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL edge_idle: got %b want 0", irq_out); end
    irq_src = 3'b010;
    tick();
    irq_src = 3'b000;
    n_cmp++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL edge_lat1: got %b want 0", irq_out); end
    tick();
    n_cmp++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL edge_lat2: got %b want 1", irq_out); end
    tick();
    n_cmp++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL edge_hold: got %b want 1", irq_out); end
    csr_wr(4'd1, 64'd2, 8'h01);
    n_cmp++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL w1c_lat1: got %b want 1", irq_out); end
    tick();
    n_cmp++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL w1c_lat2: got %b want 0", irq_out); end
  endtask

  task automatic test_level();
    logic [63:0] d;
    logic v;
    csr_wr(4'd3, 64'd0, 8'h01);
    irq_src = 3'b001;
    tick();
    csr_wr(4'd1, 64'd1, 8'h01);
    csr_rd(4'd1, d, v);
    n_cmp++; if (d !== 64'd1) begin n_fail++; $display("FAIL level_w1c_held: got %h want %h", d, 64'd1); end
    irq_src = 3'b000;
    tick();
    csr_wr(4'd1, 64'd1, 8'h01);
    csr_rd(4'd1, d, v);
    n_cmp++; if (d !== 64'd0) begin n_fail++; $display("FAIL level_w1c_clear: got %h want %h", d, 64'd0); end
  endtask

  task automatic test_race();
    logic [63:0] d;
    logic v;
    csr_wr(4'd3, 64'd7, 8'h01);
    csr_rd(4'd10, d, v);
    n_cmp++; if (d !== 64'd1) begin n_fail++; $display("FAIL race_cnt_before: got %h want %h", d, 64'd1); end
    csr_address    = 4'd1;
    csr_writedata  = 64'd4;
    csr_byteenable = 8'h01;
    csr_write      = 1'b1;
    irq_src        = 3'b100;
    tick();
    csr_write      = 1'b0;
    csr_byteenable = 8'h00;
    csr_rd(4'd1, d, v);
    n_cmp++; if (d !== 64'd4) begin n_fail++; $display("FAIL race_pending: got %h want %h", d, 64'd4); end
    csr_rd(4'd10, d, v);
    n_cmp++; if (d !== 64'd2) begin n_fail++; $display("FAIL race_count2: got %h want %h", d, 64'd2); end
    irq_src = 3'b000;
    tick();
    csr_wr(4'd1, 64'd4, 8'h01);
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    logic v;
    logic [3:0]  addrs [4] = '{4'd0, 4'd2, 4'd3, 4'd15};
    logic [63:0] exps  [4] = '{64'd5, 64'd2, 64'd7, 64'd0};
    irq_src     = 3'b101;
    csr_read    = 1'b1;
    csr_address = addrs[0];
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) csr_address = addrs[i + 1];
      else csr_read = 1'b0;
      n_cmp++; if (csr_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid%0d: got %b want 1", i, csr_readdatavalid); end
      n_cmp++; if (csr_readdata !== exps[i]) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", i, csr_readdata, exps[i]); end
    end
    tick();
    n_cmp++; if (csr_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_end: got %b want 0", csr_readdatavalid); end
    n_cmp++; if (csr_readdata !== 64'd0) begin n_fail++; $display("FAIL b2b_hold: got %h want %h", csr_readdata, 64'd0); end
    irq_src = 3'b000;
    csr_wr(4'd2, 64'hFF, 8'h00);
    csr_rd(4'd2, d, v);
    n_cmp++; if (d !== 64'd2) begin n_fail++; $display("FAIL be_zero_enable: got %h want %h", d, 64'd2); end
    csr_address    = 4'd2;
    csr_writedata  = 64'd3;
    csr_byteenable = 8'h01;
    csr_write      = 1'b1;
    csr_read       = 1'b1;
    tick();
    csr_write      = 1'b0;
    csr_read       = 1'b0;
    csr_byteenable = 8'h00;
    n_cmp++; if (csr_readdata !== 64'd2) begin n_fail++; $display("FAIL rd_before_wr: got %h want %h", csr_readdata, 64'd2); end
    csr_rd(4'd2, d, v);
    n_cmp++; if (d !== 64'd3) begin n_fail++; $display("FAIL rd_after_wr: got %h want %h", d, 64'd3); end
  endtask

  task automatic test_saturation();
    logic [63:0] d;
    logic v;
    irq_src = 3'b000;
    csr_wr(4'd1, 64'd7, 8'h01);
    csr_rd(4'd8, d, v);
    n_cmp++; if (d !== 64'd3) begin n_fail++; $display("FAIL sat_base: got %h want %h", d, 64'd3); end
    for (int i = 0; i < 300; i++) begin
      irq_src = 3'b001;
      tick();
      irq_src = 3'b000;
      csr_wr(4'd1, 64'd1, 8'h01);
      if (i == 2) begin
        csr_rd(4'd8, d, v);
        n_cmp++; if (d !== 64'd6) begin n_fail++; $display("FAIL sat_mid: got %h want %h", d, 64'd6); end
      end
    end
    csr_rd(4'd8, d, v);
    n_cmp++; if (d !== 64'hFF) begin n_fail++; $display("FAIL sat_full: got %h want %h", d, 64'hFF); end
    csr_wr(4'd4, 64'd2, 8'h01);
    csr_rd(4'd8, d, v);
    n_cmp++; if (d !== 64'd0) begin n_fail++; $display("FAIL cnt_clear: got %h want %h", d, 64'd0); end
    csr_rd(4'd4, d, v);
    n_cmp++; if (d !== 64'd0) begin n_fail++; $display("FAIL ctrl_readback: got %h want %h", d, 64'd0); end
  endtask

  task automatic test_reset_mid();
    csr_address = 4'd3;
    csr_read    = 1'b1;
    tick();
    n_cmp++; if (csr_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL mid_valid_pre: got %b want 1", csr_readdatavalid); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (csr_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_cleared: got %b want 0", csr_readdatavalid); end
    n_cmp++; if (csr_readdata !== 64'd0) begin n_fail++; $display("FAIL mid_rdata_cleared: got %h want 0", csr_readdata); end
    tick();
    csr_read = 1'b0;
    n_cmp++; if (csr_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL mid_no_resp: got %b want 0", csr_readdatavalid); end
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n        = 1'b0;
    irq_src        = 3'b000;
    csr_address    = 4'd0;
    csr_read       = 1'b0;
    csr_write      = 1'b0;
    csr_writedata  = 64'd0;
    csr_byteenable = 8'h00;
    test_reset();
    test_edge();
    test_level();
    test_race();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_asp_irq_ctrl
